// File: rtl/priority_arbiter.sv
// -----------------------------------------------------------------------------
// priority_arbiter
//
// Purpose:
//   Single-grant arbiter for N requesters. From IDLE it picks one requester,
//   then holds that grant in GRANT until the grantee releases it. It can pick
//   in two ways. Fixed mode picks the highest set index. Round-robin mode
//   searches downward from a rotating pointer. After every grant the pointer
//   moves to one below the winner, whatever the mode.
//
//   All outputs come straight from flops. There is no combinational path from
//   req, rr_mode or done to any output.
//
// Parameters:
//   N  number of requesters (2..64, need not be a power of two)
//   W  width of the grant index, $clog2(N)
//
// Ports:
//   clk           in   1  clock, rising edge
//   reset_n       in   1  asynchronous active-low reset
//   req           in   N  request vector, bit i = requester i
//   rr_mode       in   1  0 = fixed priority, 1 = round-robin (sampled in IDLE)
//   done          in   1  one-cycle release pulse from the current grantee
//   grant_valid   out  1  a grant is active
//   grant_idx     out  W  index of the granted requester (always < N)
//   grant_onehot  out  N  one-hot grant, all zero when grant_valid = 0
// -----------------------------------------------------------------------------
module priority_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         rr_mode,
  input  logic         done,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [W-1:0] LP_PTR_TOP = W'(N - 1);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Returns the index of the highest set bit of v, or 0 if v is empty.
  // The loop bound is N, so the result can never reach N, even when N is
  // not a power of two.
  function automatic logic [W-1:0] f_highest(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // Decodes an index into a one-hot vector.
  function automatic logic [N-1:0] f_onehot(input logic [W-1:0] idx);
    logic [N-1:0] oh;
    oh = '0;
    for (int i = 0; i < N; i++) begin
      oh[i] = (W'(i) == idx);
    end
    return oh;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t       r_state,        w_state_next;
  logic [W-1:0] r_ptr,          w_ptr_next;
  logic [W-1:0] r_grant_idx,    w_grant_idx_next;
  logic [N-1:0] r_grant_onehot, w_grant_onehot_next;

  // ---------------------------------------------------------------------------
  // Arbitration (only used in IDLE)
  // ---------------------------------------------------------------------------
  logic [N-1:0] w_ptr_mask;      // bits [r_ptr:0] set
  logic [N-1:0] w_req_below;     // requests at or below the pointer
  logic [W-1:0] w_fixed_idx;
  logic [W-1:0] w_rr_idx;
  logic [W-1:0] w_win_idx;
  logic [W-1:0] w_win_ptr;
  logic         w_release;

  always_comb begin
    w_ptr_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_ptr_mask[i] = (W'(i) <= r_ptr);
    end
  end

  assign w_req_below = req & w_ptr_mask;
  assign w_fixed_idx = f_highest(req);

  // The round-robin search goes downward from ptr and wraps from 0 to N-1.
  // The first hit at or below ptr is the highest set bit of the masked
  // vector. If nothing is set there, the search wraps, and the first hit is
  // simply the highest set bit of all of req.
  assign w_rr_idx  = (|w_req_below) ? f_highest(w_req_below) : w_fixed_idx;
  assign w_win_idx = rr_mode ? w_rr_idx : w_fixed_idx;
  assign w_win_ptr = (w_win_idx == '0) ? LP_PTR_TOP : (w_win_idx - 1'b1);

  // The grant ends when the grantee signals done, or when it withdraws its
  // request.
  assign w_release = done | ~req[r_grant_idx];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here is given a default first, so no path
    // leaves one unassigned and no latch is inferred.
    w_state_next        = r_state;
    w_ptr_next          = r_ptr;
    w_grant_idx_next    = r_grant_idx;
    w_grant_onehot_next = r_grant_onehot;

    unique case (r_state)
      ST_IDLE: begin
        // A done pulse in IDLE has no meaning and is ignored.
        if (|req) begin
          w_state_next        = ST_GRANT;
          w_grant_idx_next    = w_win_idx;
          w_grant_onehot_next = f_onehot(w_win_idx);
          w_ptr_next          = w_win_ptr;
        end
      end
      ST_GRANT: begin
        // After a release the FSM always passes through IDLE. A request that
        // arrives on the release cycle is therefore arbitrated one cycle
        // later.
        if (w_release) begin
          w_state_next        = ST_IDLE;
          w_grant_idx_next    = '0;
          w_grant_onehot_next = '0;
        end
      end
      default: begin
        w_state_next        = ST_IDLE;
        w_grant_idx_next    = '0;
        w_grant_onehot_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the block holds only a few control and output flops, and all of
  // them are reset asynchronously. A grant in flight is therefore dropped the
  // moment reset_n falls, with no release handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_ptr          <= LP_PTR_TOP;
      r_grant_idx    <= '0;
      r_grant_onehot <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All flops then
      // update together at the edge, with no ordering races.
      r_state        <= w_state_next;
      r_ptr          <= w_ptr_next;
      r_grant_idx    <= w_grant_idx_next;
      r_grant_onehot <= w_grant_onehot_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (register-driven only)
  // ---------------------------------------------------------------------------
  assign grant_valid  = (r_state == ST_GRANT);
  assign grant_idx    = r_grant_idx;
  assign grant_onehot = r_grant_onehot;

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the number of requesters (legal range 2..64, non-power-of-two allowed).
REQ-002 The block SHALL have parameter W, default $clog2(N), meaning the width of the grant index.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  input  1  clock; all state updates on rising edge.
REQ-005 Port: reset_n  input  1  asynchronous active-low reset.
REQ-006 Port: req  input  N  request vector, bit i = requester i.
REQ-007 Port: rr_mode  input  1  0 = fixed priority, 1 = round-robin.
REQ-008 Port: done  input  1  single-cycle pulse from the current grantee releasing the grant.
REQ-009 Port: grant_valid  output  1  a grant is active.
REQ-010 Port: grant_idx  output  W  index of the granted requester.
REQ-011 Port: grant_onehot  output  N  one-hot form of grant_idx, all zero when grant_valid=0.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (no grant) and GRANT (grant held).
REQ-013 In IDLE with req != 0, the block SHALL arbitrate and enter GRANT on the next rising edge, so grant_valid rises exactly 1 cycle after req is sampled non-zero.
REQ-014 In IDLE with req == 0, the block SHALL stay in IDLE with grant_valid=0.
REQ-015 Fixed mode SHALL grant the highest set index of req (bit N-1 highest priority, bit 0 lowest).
REQ-016 Round-robin mode SHALL search downward from pointer ptr, wrapping from 0 to N-1, and grant the first set bit found.
REQ-017 After every grant to index k, ptr SHALL become k-1, or N-1 when k=0, regardless of mode.
REQ-018 ptr SHALL equal N-1 after reset, so the first round-robin grant matches fixed mode.
REQ-019 rr_mode SHALL be sampled only in the IDLE arbitration cycle; changes during GRANT have no effect on the current grant.
REQ-020 In GRANT, grant_idx and grant_onehot SHALL be registered and stable until release.
REQ-021 Release SHALL occur when done=1, or when req[grant_idx]=0 (requester withdrew); either condition returns the FSM to IDLE on the next edge.
REQ-022 grant_valid SHALL fall 1 cycle after the release condition, and the block SHALL spend at least one IDLE cycle between consecutive grants.
REQ-023 A done pulse while in IDLE SHALL be ignored.
REQ-024 A release and a new request in the same cycle SHALL produce no grant in that transition; the new request is arbitrated in the following IDLE cycle.
REQ-025 grant_idx SHALL never take a value >= N, including when N is not a power of two.
REQ-026 The block SHALL contain no combinational path from req, rr_mode or done to any output.

Reset
REQ-027 While reset_n=0, grant_valid=0, grant_idx=0, grant_onehot=0, FSM=IDLE and ptr=N-1, applied immediately without waiting for clk.
REQ-028 Reset asserted mid-grant SHALL drop the grant immediately, with no release handshake required.
REQ-029 After reset_n deasserts, the first arbitration SHALL occur on the first rising edge at which req != 0.

Verification
REQ-030 N=8, fixed mode, req=0000_0001: after 1 cycle, grant_valid=1, grant_idx=0, grant_onehot=0000_0001.
REQ-031 N=8, fixed mode, req=1111_1111 held, done pulsed in each GRANT: every grant has grant_idx=7, with one IDLE cycle between grants.
REQ-032 N=8, rr_mode=1, req=1111_1111 held, done pulsed each grant: grant_idx sequence is 7,6,5,4,3,2,1,0,7 (wrap).
REQ-033 N=8, grant idx=5 active, req[5] cleared with done=0: grant_valid=0 on the next edge; the next grant goes to the remaining requester per the active mode.
REQ-034 reset_n pulled low mid-grant, between clock edges: all outputs are 0 immediately; after release with rr_mode=1 and req=1111_1111, the first grant is 7.
REQ-035 N=5 instance, rr_mode=1, req=10001 held with done pulsed: sequence is 4,0,4,0; grant_idx is never above 4 and grant_onehot is 5 bits wide.
